// File: rtl/noc_pipe_pkg.sv
// ---------------------------------------------------------------------------
// noc_pipe_pkg
//   Shared helpers for the NoC link pipeline blocks.
//   cnt_width(stages): width of an occupancy counter able to hold 0 .. 2*stages
//   beats (the skid-mode capacity). Never returns less than 1.
// ---------------------------------------------------------------------------
package noc_pipe_pkg;

    function automatic int cnt_width(input int stages);
        int w;
        w = $clog2(2 * stages + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//   One registered valid/ready stage with synchronous flush.
//   SKID=1 : 2-entry skid buffer (main + skid register). ready_up comes
//            straight from a flop, which breaks the combinational ready path.
//   SKID=0 : single forward register. ready_up is combinational.
//
// Ports
//   clk, rst      clock, synchronous active-high reset (clears flags and data)
//   flush_i       drop every held beat; data registers keep their contents
//   data_up/valid_up/ready_up   upstream handshake
//   data_dn/valid_dn/ready_dn   downstream handshake
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int DWIDTH = 16,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [DWIDTH-1:0] data_up,
    input  logic              valid_up,
    output logic              ready_up,
    output logic [DWIDTH-1:0] data_dn,
    output logic              valid_dn,
    input  logic              ready_dn
);

    if (SKID != 0) begin : g_skid
        logic              m_v;
        logic              s_v;
        logic [DWIDTH-1:0] m_d;
        logic [DWIDTH-1:0] s_d;
        logic              take_in;
        logic              main_free;

        // ready_up depends only on s_v, so upstream never sees a
        // combinational path from ready_dn.
        assign ready_up  = ~s_v;
        assign take_in   = valid_up & ~s_v;
        assign main_free = ~m_v | ready_dn;

        always_ff @(posedge clk) begin
            if (rst) begin
                m_v <= 1'b0;
                s_v <= 1'b0;
                m_d <= '0;
                s_d <= '0;
            end else if (flush_i) begin
                m_v <= 1'b0;
                s_v <= 1'b0;
            end else if (main_free) begin
                // A full skid always drains first; ready_up is low in that
                // cycle, so take_in cannot also be set.
                if (s_v) begin
                    m_d <= s_d;
                    m_v <= 1'b1;
                    s_v <= 1'b0;
                end else begin
                    m_v <= take_in;
                    if (take_in) begin
                        m_d <= data_up;
                    end
                end
            end else if (take_in) begin
                // Main is stalled: park the accepted beat in the skid.
                s_d <= data_up;
                s_v <= 1'b1;
            end
        end

        assign data_dn  = m_d;
        assign valid_dn = m_v;
    end else begin : g_fwd
        logic              v;
        logic [DWIDTH-1:0] d;

        assign ready_up = ~v | ready_dn;

        always_ff @(posedge clk) begin
            if (rst) begin
                v <= 1'b0;
                d <= '0;
            end else if (flush_i) begin
                v <= 1'b0;
            end else if (valid_up && ready_up) begin
                d <= data_up;
                v <= 1'b1;
            end else if (ready_dn) begin
                v <= 1'b0;
            end
        end

        assign data_dn  = d;
        assign valid_dn = v;
    end

endmodule

// File: rtl/reg_pipeline_chain.sv
// ---------------------------------------------------------------------------
// reg_pipeline_chain
//   Cascade of STAGES registered valid/ready stages for long NoC links.
//   SKID=1 registers the ready path too (capacity 2 beats per stage),
//   SKID=0 registers only the forward path (capacity 1 beat per stage).
//   STAGES=0 is a pure wire-through with no registers.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush_i           synchronous drop of all held beats
//   data_i/valid_i    upstream payload / valid,  ready_o  ready to upstream
//   data_o/valid_o    downstream payload / valid, ready_i  downstream ready
//   occupancy_o       registered count of beats held in the chain
// ---------------------------------------------------------------------------
module reg_pipeline_chain
    import noc_pipe_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int STAGES = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = cnt_width(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  occupancy_o
);

    // Index k is the interface in front of stage k; index STAGES is the
    // downstream port. With STAGES=0 both ends collapse onto index 0.
    logic [STAGES:0][DWIDTH-1:0] d_chain;
    logic [STAGES:0]             v_chain;
    logic [STAGES:0]             r_chain;

    assign d_chain[0]      = data_i;
    assign v_chain[0]      = valid_i;
    assign r_chain[STAGES] = ready_i;

    assign data_o  = d_chain[STAGES];
    assign valid_o = v_chain[STAGES];
    assign ready_o = r_chain[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_skid_stage #(
            .DWIDTH (DWIDTH),
            .SKID   (SKID)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush_i  (flush_i),
            .data_up  (d_chain[k]),
            .valid_up (v_chain[k]),
            .ready_up (r_chain[k]),
            .data_dn  (d_chain[k+1]),
            .valid_dn (v_chain[k+1]),
            .ready_dn (r_chain[k+1])
        );
    end

    if (STAGES == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, flush_i};
        assign occupancy_o = '0;
    end else begin : g_count
        logic [CNT_W-1:0] occ;
        logic             beat_in;
        logic             beat_out;

        // A beat offered during flush never enters the chain; a beat handed
        // downstream during flush has still left it.
        assign beat_in  = valid_i & ready_o & ~flush_i;
        assign beat_out = valid_o & ready_i;

        always_ff @(posedge clk) begin
            if (rst || flush_i) begin
                occ <= '0;
            end else if (beat_in && !beat_out) begin
                occ <= occ + CNT_W'(1);
            end else if (!beat_in && beat_out) begin
                occ <= occ - CNT_W'(1);
            end
        end

        assign occupancy_o = occ;
    end

endmodule

// File: tb/tb_reg_pipeline_chain.sv
// ---------------------------------------------------------------------------
// tb_reg_pipeline_chain
//   Directed checks on a STAGES=2/SKID=1 chain and a STAGES=0 bypass, plus
//   random-handshake scoreboards on STAGES=1/3 in both SKID modes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_pipeline_chain;
    import noc_pipe_pkg::*;

    localparam int NBEATS = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed DUT: STAGES=2, SKID=1 ----------------
    logic        a_rst   = 1'b1;
    logic        a_flush = 1'b0;
    logic [15:0] a_di    = '0;
    logic        a_vi    = 1'b0;
    logic        a_ri    = 1'b0;
    logic        a_ro;
    logic [15:0] a_do;
    logic        a_vo;
    logic [2:0]  a_occ;

    reg_pipeline_chain #(.DWIDTH(16), .STAGES(2), .SKID(1)) u_dut_a (
        .clk         (clk),
        .rst         (a_rst),
        .flush_i     (a_flush),
        .data_i      (a_di),
        .valid_i     (a_vi),
        .ready_o     (a_ro),
        .data_o      (a_do),
        .valid_o     (a_vo),
        .ready_i     (a_ri),
        .occupancy_o (a_occ)
    );

    // ---------------- bypass DUT: STAGES=0 ----------------
    logic        z_rst   = 1'b0;
    logic        z_flush = 1'b0;
    logic [15:0] z_di    = '0;
    logic        z_vi    = 1'b0;
    logic        z_ri    = 1'b0;
    logic        z_ro;
    logic [15:0] z_do;
    logic        z_vo;
    logic [0:0]  z_occ;

    reg_pipeline_chain #(.DWIDTH(16), .STAGES(0), .SKID(1)) u_dut_z (
        .clk         (clk),
        .rst         (z_rst),
        .flush_i     (z_flush),
        .data_i      (z_di),
        .valid_i     (z_vi),
        .ready_o     (z_ro),
        .data_o      (z_do),
        .valid_o     (z_vo),
        .ready_i     (z_ri),
        .occupancy_o (z_occ)
    );

    // Scoreboard for DUT A: push on accepted input, pop on delivered output.
    logic [15:0] q_a[$];

    always @(negedge clk) begin
        if (a_rst) begin
            q_a.delete();
        end else begin
            chk("a_occ_model", 64'(a_occ), 64'(q_a.size()));
            if (!a_flush && a_vi && a_ro) q_a.push_back(a_di);
            if (a_vo && a_ri) begin
                if (q_a.size() == 0) chk("a_extra_beat", 64'(q_a.size()), 64'd1);
                else chk("a_order", 64'(a_do), 64'(q_a.pop_front()));
            end
            if (a_flush) q_a.delete();
        end
    end

    task automatic cyc_a(input logic v, input logic [15:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        a_vi    = v;
        a_di    = d;
        a_ri    = r;
        a_flush = f;
        @(negedge clk);
    endtask

    // ---------------- random DUTs: STAGES 1/3 x SKID 0/1 ----------------
    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int RS = (g % 2 == 1) ? 3 : 1;
        localparam int RK = (g >= 2) ? 1 : 0;
        localparam int RW = cnt_width(RS);

        logic          r_rst = 1'b1;
        logic [15:0]   r_di  = '0;
        logic          r_vi  = 1'b0;
        logic          r_ri  = 1'b0;
        logic          r_ro;
        logic [15:0]   r_do;
        logic          r_vo;
        logic [RW-1:0] r_occ;
        logic          done  = 1'b0;
        logic [15:0]   q[$];

        reg_pipeline_chain #(.DWIDTH(16), .STAGES(RS), .SKID(RK)) u_dut (
            .clk         (clk),
            .rst         (r_rst),
            .flush_i     (1'b0),
            .data_i      (r_di),
            .valid_i     (r_vi),
            .ready_o     (r_ro),
            .data_o      (r_do),
            .valid_o     (r_vo),
            .ready_i     (r_ri),
            .occupancy_o (r_occ)
        );

        initial begin
            int   sent;
            logic hold;
            sent = 0;
            hold = 1'b0;
            repeat (2) @(posedge clk);
            #1 r_rst = 1'b0;
            while (sent < NBEATS) begin
                @(posedge clk);
                #1;
                if (!hold) begin
                    r_vi = 1'($urandom_range(0, 1));
                    r_di = 16'($urandom);
                end
                r_ri = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("rnd_occ", 64'(r_occ), 64'(q.size()));
                if (r_vi && r_ro) begin
                    q.push_back(r_di);
                    sent++;
                    hold = 1'b0;
                end else begin
                    hold = r_vi;
                end
                if (r_vo && r_ri) begin
                    if (q.size() == 0) chk("rnd_extra_beat", 64'(q.size()), 64'd1);
                    else chk("rnd_data", 64'(r_do), 64'(q.pop_front()));
                end
            end
            for (int t = 0; t < 200 && q.size() > 0; t++) begin
                @(posedge clk);
                #1;
                r_vi = 1'b0;
                r_ri = 1'b1;
                @(negedge clk);
                if (r_vo) begin
                    if (q.size() == 0) chk("rnd_extra_beat", 64'(q.size()), 64'd1);
                    else chk("rnd_data", 64'(r_do), 64'(q.pop_front()));
                end
            end
            chk("rnd_drained", 64'(q.size()), 64'd0);
            done = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          acc;
        logic [15:0] v;
        logic [3:0]  rdone;

        repeat (2) @(posedge clk);
        #1 a_rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(a_vo), 64'd0);
        chk("rst_data", 64'(a_do), 64'd0);
        chk("rst_occ", 64'(a_occ), 64'd0);
        chk("rst_ready", 64'(a_ro), 64'd1);

        // Streaming with ready_i=1: 2-cycle latency, occupancy settles at 2.
        for (int i = 1; i <= 64; i++) begin
            cyc_a(1'b1, 16'(i), 1'b1, 1'b0);
            chk("stream_ready", 64'(a_ro), 64'd1);
            chk("stream_occ", 64'(a_occ), 64'((i - 1 < 2) ? i - 1 : 2));
            chk("stream_valid", 64'(a_vo), 64'(i >= 3));
            if (i >= 3) chk("stream_data", 64'(a_do), 64'(i - 2));
        end
        repeat (3) cyc_a(1'b0, 16'h0, 1'b1, 1'b0);
        chk("drain_valid", 64'(a_vo), 64'd0);
        chk("drain_occ", 64'(a_occ), 64'd0);

        // Backpressure: 4 beats fit, then ready_o drops.
        acc = 0;
        v   = 16'h0101;
        for (int c = 0; c < 10; c++) begin
            cyc_a(1'b1, v, 1'b0, 1'b0);
            chk("bp_ready", 64'(a_ro), 64'(acc < 4));
            chk("bp_occ", 64'(a_occ), 64'(acc));
            if (acc < 4) begin
                acc++;
                v++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            cyc_a(1'b0, 16'h0, 1'b1, 1'b0);
            chk("release_valid", 64'(a_vo), 64'd1);
            chk("release_data", 64'(a_do), 64'(16'h0101 + k));
        end
        cyc_a(1'b0, 16'h0, 1'b1, 1'b0);
        chk("release_empty", 64'(a_vo), 64'd0);
        chk("release_occ", 64'(a_occ), 64'd0);

        // Flush with 3 beats held and 0xBEEF offered in the flush cycle.
        for (int c = 0; c < 3; c++) cyc_a(1'b1, 16'(16'h0201 + c), 1'b0, 1'b0);
        cyc_a(1'b1, 16'hBEEF, 1'b0, 1'b1);
        chk("flush_pre_occ", 64'(a_occ), 64'd3);
        chk("flush_pre_ready", 64'(a_ro), 64'd1);
        cyc_a(1'b0, 16'h0, 1'b0, 1'b0);
        chk("flush_valid", 64'(a_vo), 64'd0);
        chk("flush_occ", 64'(a_occ), 64'd0);
        chk("flush_ready", 64'(a_ro), 64'd1);
        cyc_a(1'b1, 16'h0301, 1'b1, 1'b0);
        chk("post_flush_idle", 64'(a_vo), 64'd0);
        cyc_a(1'b0, 16'h0, 1'b1, 1'b0);
        chk("post_flush_idle", 64'(a_vo), 64'd0);
        cyc_a(1'b0, 16'h0, 1'b1, 1'b0);
        chk("post_flush_valid", 64'(a_vo), 64'd1);
        chk("post_flush_data", 64'(a_do), 64'h0301);
        cyc_a(1'b0, 16'h0, 1'b1, 1'b0);

        // Reset with the chain full.
        for (int c = 0; c < 4; c++) cyc_a(1'b1, 16'(16'h0401 + c), 1'b0, 1'b0);
        cyc_a(1'b0, 16'h0, 1'b0, 1'b0);
        chk("full_occ", 64'(a_occ), 64'd4);
        chk("full_ready", 64'(a_ro), 64'd0);
        chk("full_head", 64'(a_do), 64'h0401);
        @(posedge clk);
        #1 a_rst = 1'b1;
        @(posedge clk);
        #1 a_rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(a_vo), 64'd0);
        chk("midrst_data", 64'(a_do), 64'd0);
        chk("midrst_occ", 64'(a_occ), 64'd0);
        chk("midrst_ready", 64'(a_ro), 64'd1);

        // STAGES=0 bypass follows its inputs within the cycle.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            z_di    = 16'($urandom);
            z_vi    = k[0];
            z_ri    = k[1];
            z_flush = k[2];
            #1;
            chk("byp_data", 64'(z_do), 64'(z_di));
            chk("byp_valid", 64'(z_vo), 64'(z_vi));
            chk("byp_ready", 64'(z_ro), 64'(z_ri));
            chk("byp_occ", 64'(z_occ), 64'd0);
        end

        rdone = {g_rnd[3].done, g_rnd[2].done, g_rnd[1].done, g_rnd[0].done};
        for (int t = 0; t < 80000 && rdone != 4'hF; t++) begin
            @(posedge clk);
            rdone = {g_rnd[3].done, g_rnd[2].done, g_rnd[1].done, g_rnd[0].done};
        end
        chk("rnd_finished", 64'(rdone), 64'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_pipeline_chain.md
Name: reg_pipeline_chain

Overview:
- Parametrised chain of registered valid/ready pipeline stages; generalises the single forward-registered stage.
- Adds configurable depth and an optional skid-buffer mode that also registers the ready path, so long NoC links get timing closure at full throughput.
- Adds a synchronous flush and an occupancy count.
- Used on router-to-router links and at long-wire crossings between tiles.

Parameters:
- DWIDTH, 16, payload width in bits.
- STAGES, 2, number of cascaded stages (0 = combinational pass-through).
- SKID, 1, 1 = each stage is a 2-entry skid buffer with registered ready_o; 0 = forward-registered stage with combinational ready.
- CNT_W, $clog2(2*STAGES+1) (min 1), occupancy counter width (derived; do not override).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush_i  input  1  synchronous drop of all held beats.
- data_i  input  DWIDTH  upstream payload.
- valid_i  input  1  upstream valid.
- ready_o  output  1  ready to upstream.
- data_o  output  DWIDTH  downstream payload.
- valid_o  output  1  downstream valid.
- ready_i  input  1  downstream ready.
- occupancy_o  output  CNT_W  number of beats currently held in the chain.

Behaviour:
- Transfer occurs on any edge where valid & ready are both high at that interface. Beats are never duplicated, dropped (except by flush/rst) or reordered.
- Reset (rst=1 at the edge):
  - All stage valid and skid-valid flags go to 0; all data registers go to 0.
  - After reset: valid_o=0, data_o=0, occupancy_o=0, ready_o=1 (STAGES>0).
  - Reset mid-transfer discards the in-flight beats.
- SKID=0 stage:
  - ready_up = ~v | ready_dn (combinational).
  - On valid_up & ready_up: load data, set v.
  - Else on v & ready_dn: clear v.
- SKID=1 stage: main register (m_v, m_d) and skid register (s_v, s_d).
  - ready_up = ~s_v, taken directly from a flop.
  - Input accepted while m_v & ~ready_dn: goes to skid (s_v<=1).
  - When ~m_v | ready_dn: main loads from skid if s_v (s_v<=0), else from input if accepted.
  - Accepting input in the same cycle the skid drains is not allowed, because ready_up=0 in that cycle.
- Latency: one cycle per stage from valid_i to valid_o when unstalled. Throughput is 1 beat/cycle in both modes.
- Capacity: STAGES beats (SKID=0), 2*STAGES beats (SKID=1).
- STAGES=0: data_o=data_i, valid_o=valid_i, ready_o=ready_i, occupancy_o=0. No registers.
- Backpressure: with ready_i held 0, the chain fills to capacity, then ready_o=0.
  - SKID=1: ready_o falls on the cycle after the last skid fills.
  - SKID=0: ready_o falls combinationally.
- flush_i:
  - At the edge, clears every m_v and s_v, and occupancy goes to 0.
  - A beat offered on valid_i in the flush cycle is discarded even if ready_o=1.
  - A beat presented on valid_o in the flush cycle counts as delivered if ready_i=1.
  - Data registers are not cleared.
  - rst has priority over flush_i.
- occupancy_o: registered. Updated as +1 on accepted input, -1 on delivered output, ±0 when both occur or neither. Never exceeds capacity or underflows.

Decomposition:
- Package noc_pipe_pkg: function cnt_width(stages) returning max(1,$clog2(2*stages+1)).
- One sub-module, pipe_skid_stage (DWIDTH, SKID). It contains one stage with flush and is instantiated STAGES times via generate.
- The top holds the cascade, the STAGES=0 bypass and the occupancy counter.

Test Plan:
- Reset, then stream 0x0001..0x0040 with ready_i=1 (STAGES=2, SKID=1): first valid_o 2 cycles after first valid_i, then one beat/cycle in order, and occupancy_o stays 2.
- Hold ready_i=0 while streaming: 4 beats are accepted, ready_o=0 from the cycle after the 4th acceptance, and occupancy_o=4. Release ready_i: values emerge in order with no bubble and no loss.
- Random valid_i/ready_i (50%) for 10k beats in SKID=0 and SKID=1, each with STAGES=1 and 3: a scoreboard matches every beat exactly once in order.
- Assert flush_i while occupancy_o=3 and valid_i=1 with value 0xBEEF: next cycle valid_o=0 and occupancy_o=0, and 0xBEEF never appears at data_o.
- Assert rst for 1 cycle with the chain full: next cycle valid_o=0, data_o=0, occupancy_o=0, ready_o=1.
- STAGES=0: data_o/valid_o follow inputs in the same cycle, ready_o equals ready_i, and occupancy_o stays 0.
